// File: rtl/display_pkg.sv
// Shared display types and active-low segment/anode constants.
// Used by display_scan_controller and seg7_decoder.
package display_pkg;

    typedef enum logic [1:0] {
        OFF,
        BLANK,
        DRIVE
    } state_t;

    // Patterns are {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low 7-segment pattern.
// Non-BCD nibbles (A-F) decode to a blank digit.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_BLANK;
        unique case (nibble)
            4'd0:    segments = SEG_0;
            4'd1:    segments = SEG_1;
            4'd2:    segments = SEG_2;
            4'd3:    segments = SEG_3;
            4'd4:    segments = SEG_4;
            4'd5:    segments = SEG_5;
            4'd6:    segments = SEG_6;
            4'd7:    segments = SEG_7;
            4'd8:    segments = SEG_8;
            4'd9:    segments = SEG_9;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// 4-digit multiplexed 7-segment scanner with frame-aligned BCD loads.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [6:0]  segmento,
    output logic [3:0]  anodo,
    output logic [1:0]  digit_idx
);

    localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ?
                          DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] D_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
    localparam state_t GAP = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    idx, idx_n;
    logic [15:0]   shadow, shadow_n;
    logic [15:0]   pdata;
    logic          pending;
    logic          wrap;
    logic          commit;
    logic          lz_blank;
    logic [3:0]    nib;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_n;
    logic [3:0]    an_n;

    assign load_ready = ~pending;
    assign digit_idx  = idx;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        wrap    = 1'b0;
        if (!enable) begin
            state_n = OFF;
            cnt_n   = '0;
            idx_n   = '0;
        end else begin
            unique case (state)
                OFF: begin
                    state_n = GAP;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
                BLANK: begin
                    if (cnt == B_LAST) begin
                        state_n = DRIVE;
                        cnt_n   = '0;
                    end
                end
                DRIVE: begin
                    if (cnt == D_LAST) begin
                        state_n = GAP;
                        cnt_n   = '0;
                        idx_n   = idx + 2'd1;
                        wrap    = (idx == 2'd3);
                    end
                end
                default: begin
                    state_n = OFF;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            endcase
        end
    end

    // Loads land only at frame wrap (or straight away while dark).
    assign commit   = pending && ((state == OFF) || wrap);
    assign shadow_n = commit ? pdata : shadow;
    assign nib      = shadow_n[{idx_n, 2'b00} +: 4];

    seg7_decoder u_dec (
        .nibble   (nib),
        .segments (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign lz_blank = (idx_n != 2'd0) &&
                      ((shadow_n >> {idx_n, 2'b00}) == 16'h0000);
`else
    assign lz_blank = 1'b0;
`endif

    // Outputs are computed from next state so they register in step.
    always_comb begin
        an_n  = ANODE_OFF;
        seg_n = SEG_BLANK;
        if (state_n == DRIVE) begin
            an_n  = ~(4'b0001 << idx_n);
            seg_n = lz_blank ? SEG_BLANK : dec_seg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= OFF;
            cnt      <= '0;
            idx      <= '0;
            shadow   <= 16'h0000;
            pdata    <= 16'h0000;
            pending  <= 1'b0;
            anodo    <= ANODE_OFF;
            segmento <= SEG_BLANK;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shadow   <= shadow_n;
            anodo    <= an_n;
            segmento <= seg_n;
            if (commit) begin
                pending <= 1'b0;
            end else if (load_valid && load_ready) begin
                pending <= 1'b1;
                pdata   <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller (frame-position model).
// Build with +define+LEADING_ZERO_BLANK_EN to cover leading-zero blanking.
module tb_display_scan_controller;

    localparam int D = 4;
    localparam int B = 2;
    localparam int S = D + B;
    localparam int P = 4 * S;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0000;
    logic        load_ready;
    logic [6:0]  segmento;
    logic [3:0]  anodo;
    logic [1:0]  digit_idx;

    display_scan_controller #(
        .DIGIT_CYCLES (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .segmento   (segmento),
        .anodo      (anodo),
        .digit_idx  (digit_idx)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] idx;
        logic       rdy;
    } obs_t;

    obs_t q[$];
    int   ncmp = 0;
    int   nerr = 0;
    bit   mon_on = 1'b0;

    // Reference model: position inside the frame plus load bookkeeping.
    bit          run = 1'b0;
    int          pos = 0;
    logic [15:0] sh = 16'h0;
    logic [15:0] pd = 16'h0;
    bit          pend = 1'b0;
    bit          m_acc, m_com;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0011000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic obs_t expect_now();
        obs_t o;
        int slot, w;
        o.an  = 4'hF;
        o.seg = 7'h7F;
        o.idx = 2'd0;
        o.rdy = !pend;
        if (run) begin
            slot  = pos / S;
            w     = pos % S;
            o.idx = 2'(slot);
            if (w >= B) begin
                o.an  = 4'hF ^ (4'h1 << slot);
                o.seg = ref_seg(sh[4*slot +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
                if (slot > 0 && (sh >> (4 * slot)) == 16'h0)
                    o.seg = 7'h7F;
`endif
            end
        end
        return o;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            run  = 1'b0;
            pos  = 0;
            sh   = 16'h0;
            pd   = 16'h0;
            pend = 1'b0;
            q.delete();
            q.push_back(expect_now());
        end else begin
            m_acc = load_valid && !pend;
            m_com = pend && (!run || (enable && pos == P - 1));
            if (!enable) begin
                run = 1'b0;
                pos = 0;
            end else if (!run) begin
                run = 1'b1;
                pos = 0;
            end else begin
                pos = (pos + 1) % P;
            end
            if (m_com) begin
                sh   = pd;
                pend = 1'b0;
            end
            if (m_acc) begin
                pd   = load_data;
                pend = 1'b1;
            end
            q.push_back(expect_now());
        end
    end

    always @(negedge clock) begin
        obs_t a, e;
        if (mon_on) begin
            a.an  = anodo;
            a.seg = segmento;
            a.idx = digit_idx;
            a.rdy = load_ready;
            ncmp++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL scoreboard: no expected entry at %0t", $time);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    nerr++;
                    $display("FAIL scan @%0t: got an=%b seg=%b idx=%0d rdy=%b want an=%b seg=%b idx=%0d rdy=%b",
                             $time, a.an, a.seg, a.idx, a.rdy,
                             e.an, e.seg, e.idx, e.rdy);
                end
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        ncmp++;
        if (anodo !== 4'hF || segmento !== 7'h7F ||
            load_ready !== 1'b1 || digit_idx !== 2'd0) begin
            nerr++;
            $display("FAIL %s: got an=%b seg=%b rdy=%b idx=%0d want 1111 1111111 1 0",
                     tag, anodo, segmento, load_ready, digit_idx);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        int n;
        n = 0;
        @(negedge clock);
        while (!load_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        ncmp++;
        if (n >= 500) begin
            nerr++;
            $display("FAIL load_wait: load_ready=%b after %0d cycles, want 1", load_ready, n);
        end
        load_valid = 1'b1;
        load_data  = v;
        @(negedge clock);
        load_valid = 1'b0;
    endtask

    task automatic wait_digit(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(anodo != 4'hF && digit_idx == 2'(d)) && n < 500);
        ncmp++;
        if (n >= 500) begin
            nerr++;
            $display("FAIL wait_digit%0d: idx=%0d an=%b after %0d cycles", d, digit_idx, anodo, n);
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_reset_outs("reset_init");
        #1;
        q.delete();
        mon_on = 1'b1;
        reset  = 1'b0;

        // Load while dark, then scan 0x1234.
        do_load(16'h1234);
        enable = 1'b1;
        repeat (3 * P) @(negedge clock);

        // Deferred commit plus an ignored load while pending.
        wait_digit(1);
        do_load(16'h9999);
        load_valid = 1'b1;
        load_data  = 16'h5555;
        repeat (3) @(negedge clock);
        load_valid = 1'b0;
        do_load(16'h5555);
        repeat (2 * P) @(negedge clock);

        // Invalid BCD, then disable and re-enable.
        do_load(16'h00AB);
        repeat (2 * P) @(negedge clock);
        enable = 1'b0;
        repeat (5) @(negedge clock);
        enable = 1'b1;
        repeat (P) @(negedge clock);

        // Leading-zero patterns.
        do_load(16'h0042);
        repeat (2 * P) @(negedge clock);
        do_load(16'h0000);
        repeat (2 * P) @(negedge clock);

        // Asynchronous reset in the middle of a driven digit.
        do_load(16'h8765);
        repeat (P) @(negedge clock);
        wait_digit(2);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outs("reset_async");
        @(posedge clock);
        @(negedge clock);
        #1;
        reset = 1'b0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 199) == 0)
                enable = ~enable;
            if (!(load_valid && !load_ready)) begin
                load_valid = ($urandom_range(0, 7) == 0);
                for (int k = 0; k < 4; k++)
                    load_data[4*k +: 4] = 4'($urandom_range(0, 11));
                if ($urandom_range(0, 3) == 0)
                    load_data[15:8] = 8'h00;
            end
        end
        load_valid = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        mon_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Time-multiplexed driver for a 4-digit common-anode 7-segment display. Accepts a 16-bit BCD value through a valid/ready load handshake and commits it only at frame boundaries, so digits never tear. Scans the digits with a dead-time blanking slot between them to prevent ghosting. Sits between the counter/PC datapath and the board pins, and drives the shared segment bus with active-low patterns.

Parameters:
DIGIT_CYCLES, 50000, clock cycles each digit is driven (>=1)
BLANK_CYCLES, 16, dead-time cycles with all anodes off between digits (>=0; 0 skips BLANK)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = scanning; 0 = display dark (OFF state)
load_valid  input  1  load_data valid this cycle
load_data  input  16  four BCD nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3
load_ready  output  1  1 = no load pending; can accept
segmento  output  7  active-low segments {g,f,e,d,c,b,a}
anodo  output  4  active-low digit enables; bit i = digit i
digit_idx  output  2  digit currently selected (debug/observability)

Behaviour:
- Reset values: state OFF; anodo=4'b1111; segmento=7'b1111111; digit_idx=0; shadow=16'h0000; pending=0; load_ready=1; slot counter=0.
- Clock and reset are fixed: one clock; reset is asynchronous and active-high. Reset asserted mid-frame forces reset values immediately and drops any pending load.
- Decode: 0->1000000, 1->1111001, 2->0100100, 3->0110000, 4->0011001, 5->0010010, 6->0000010, 7->1111000, 8->0000000, 9->0011000. Nibbles A-F -> 1111111 (blank).
- States: OFF, BLANK, DRIVE. Outputs are registered Moore outputs and reflect the current state.
- OFF: anodo=1111, segmento=1111111. When enable=1, go to BLANK with idx=0 on the next cycle, or to DRIVE if BLANK_CYCLES=0.
- BLANK: anodo=1111, segmento=1111111. Lasts exactly BLANK_CYCLES cycles, then goes to DRIVE.
- DRIVE: anodo has only bit idx low; segmento=decode(shadow[4*idx+:4]). Lasts exactly DIGIT_CYCLES cycles, then idx increments. idx wraps 3->0, and the next state is BLANK, or DRIVE if BLANK_CYCLES=0.
- enable=0 in any state: go to OFF next cycle, with idx=0 and the counter cleared. The shadow value is retained.
- Load handshake:
  - A load is accepted when load_valid && load_ready. It captures load_data into the pending register, sets pending=1 and drops load_ready the next cycle.
  - While load_ready=0, load_valid is ignored and the source must hold its data.
  - Commit: shadow<=pending_data, pending=0, load_ready=1. Commit happens on the DRIVE idx3 -> idx0 frame-wrap transition, or on the first cycle after acceptance while in OFF.
  - A value accepted mid-frame is first displayed on digit 0 of the next frame.
- Counter width: $clog2(max(DIGIT_CYCLES,BLANK_CYCLES)+1). The counter restarts at 0 on each state entry.
- Frame period: 4*(DIGIT_CYCLES+BLANK_CYCLES) cycles.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined: in DRIVE, a digit i>0 whose nibble is 0 is blanked (segmento=1111111, anode still asserted) if all higher nibbles are also 0. Digit 0 is never suppressed.
- When undefined: all digits are decoded as-is, so 0x0042 shows "0042".

Decomposition:
- Shared package display_pkg holds:
  - the state enum (OFF, BLANK, DRIVE);
  - the SEG_0..SEG_9 and SEG_BLANK constants;
  - the ANODE_OFF constant (4'b1111).
- One sub-module, seg7_decoder: a combinational nibble -> active-low pattern decoder, reused by other display blocks.

Test Plan:
- Reset check: assert reset mid-DRIVE -> anodo=1111, segmento=1111111, load_ready=1, digit_idx=0 in the same cycle, without waiting for a clock edge.
- Scan sequence: DIGIT_CYCLES=4, BLANK_CYCLES=2, load 0x1234, enable=1 -> repeating pattern of 2 dark cycles then 4 cycles each of:
  - anodo=1110/segmento=0011001;
  - anodo=1101/0110000;
  - anodo=1011/0100100;
  - anodo=0111/1111001.
  Period = 24 cycles.
- Deferred commit: while digit 1 is being driven, load 0x9999 -> load_ready low until the frame wrap; digits 1-3 keep old values; digit 0 of the next frame shows 0011000; then load_ready=1.
- Handshake hold: a second load_valid with 0x5555 while pending -> ignored; after commit, asserting it again is accepted.
- Invalid BCD and enable: load 0x00AB -> digits 0 and 1 blank. Drop enable -> OFF, with anodo=1111 next cycle. Re-enable -> restart at BLANK with idx=0.
- Feature: with LEADING_ZERO_BLANK_EN, load 0x0042 -> digits 3 and 2 blank, digits 1 and 0 show 4 and 2. Load 0x0000 -> only digit 0 shows 1000000.
